// File: rtl/riscv_ctrl_pkg.sv
// rtl/riscv_ctrl_pkg.sv - shared state, opcode and datapath-select encodings for the multi-cycle control FSM
package riscv_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMREAD,
        S_MEMWB,
        S_MEMWRITE,
        S_EXECR,
        S_EXECI,
        S_ALUWB,
        S_BEQ,
        S_TRAP
    } state_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam logic [1:0] IMM_I  = 2'b00;
    localparam logic [1:0] IMM_S  = 2'b01;
    localparam logic [1:0] IMM_SB = 2'b10;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RD1   = 2'b10;

    localparam logic [1:0] SRCB_RD2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_READDATA  = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

endpackage

// File: rtl/ctrl_mem_timer.sv
// rtl/ctrl_mem_timer.sv - wait-cycle counter that flags a memory access stuck past MEM_TIMEOUT cycles
module ctrl_mem_timer #(
    parameter int MEM_TIMEOUT = 16
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_clr,
    input  logic i_wait,
    output logic o_expire
);

    localparam int TW = $clog2(MEM_TIMEOUT);

    logic [TW-1:0] cnt_q, cnt_d;

    // Expiry is judged on the current wait cycle so a late ready still wins.
    assign o_expire = i_wait && (cnt_q == TW'(MEM_TIMEOUT - 1));

    always_comb begin
        cnt_d = cnt_q;
        if (i_clr) begin
            cnt_d = '0;
        end else if (i_wait) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/multicycle_ctrl_fsm.sv
// rtl/multicycle_ctrl_fsm.sv - multi-cycle RV64 main control FSM with memory handshake, traps and retire counter
module multicycle_ctrl_fsm
    import riscv_ctrl_pkg::*;
#(
    parameter int OPCODE_WIDTH = 7,
    parameter int MEM_TIMEOUT  = 16,
    parameter int CNT_WIDTH    = 64
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic [OPCODE_WIDTH-1:0] i_opcode,
    input  logic                    i_zero,
    input  logic                    i_mem_ready,
    output logic                    o_mem_req,
    output logic                    o_AdrSrc,
    output logic                    o_IRWrite,
    output logic                    o_PCWrite,
    output logic                    o_MemWrite,
    output logic                    o_RegWrite,
    output logic                    o_Branch,
    output logic [1:0]              o_ImmSrc,
    output logic [1:0]              o_ALUSrcA,
    output logic [1:0]              o_ALUSrcB,
    output logic [1:0]              o_ALUOp,
    output logic [1:0]              o_ResultSrc,
    output logic                    o_fault,
    output logic                    o_fault_cause,
    output logic [CNT_WIDTH-1:0]    o_instret
);

    state_t                 state_q, state_d;
    logic                   cause_q, cause_d;
    logic [CNT_WIDTH-1:0]   instret_q;
    logic                   retire, expire, mem_state, is_store;
    logic                   mem_req, adr_src, ir_write, pc_write, mem_write, reg_write, branch, fault;
    logic [1:0]             imm_src, alu_src_a, alu_src_b, alu_op, result_src;

    // Kept apart from the main decode so the timer's expire input has no path back through it.
    assign mem_state = (state_q == S_FETCH) || (state_q == S_MEMREAD) || (state_q == S_MEMWRITE);
    assign is_store  = (i_opcode == OPCODE_WIDTH'(OP_STORE));

    ctrl_mem_timer #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_timer (
        .i_clk    (i_clk),
        .i_rst_n  (i_rst_n),
        .i_clr    (state_d != state_q),
        .i_wait   (mem_state && !i_mem_ready),
        .o_expire (expire)
    );

    always_comb begin
        state_d    = state_q;
        cause_d    = cause_q;
        retire     = 1'b0;
        mem_req    = 1'b0;
        adr_src    = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        mem_write  = 1'b0;
        reg_write  = 1'b0;
        branch     = 1'b0;
        fault      = 1'b0;
        imm_src    = IMM_I;
        alu_src_a  = SRCA_PC;
        alu_src_b  = SRCB_RD2;
        alu_op     = ALUOP_ADD;
        result_src = RES_ALUOUT;
        case (state_q)
            S_FETCH: begin
                mem_req    = 1'b1;
                alu_src_b  = SRCB_FOUR;
                result_src = RES_ALURESULT;
                if (i_mem_ready) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    state_d  = S_DECODE;
                end else if (expire) begin
                    cause_d = 1'b1;
                    state_d = S_TRAP;
                end
            end
            S_DECODE: begin
                alu_src_a = SRCA_OLDPC;
                alu_src_b = SRCB_IMM;
                imm_src   = IMM_SB;
                case (i_opcode)
                    OPCODE_WIDTH'(OP_LOAD),
                    OPCODE_WIDTH'(OP_STORE):  state_d = S_MEMADR;
                    OPCODE_WIDTH'(OP_RTYPE):  state_d = S_EXECR;
                    OPCODE_WIDTH'(OP_ITYPE):  state_d = S_EXECI;
                    OPCODE_WIDTH'(OP_BRANCH): state_d = S_BEQ;
                    default: begin
                        cause_d = 1'b0;
                        state_d = S_TRAP;
                    end
                endcase
            end
            S_MEMADR: begin
                alu_src_a = SRCA_RD1;
                alu_src_b = SRCB_IMM;
                imm_src   = is_store ? IMM_S : IMM_I;
                state_d   = is_store ? S_MEMWRITE : S_MEMREAD;
            end
            S_MEMREAD: begin
                mem_req = 1'b1;
                adr_src = 1'b1;
                if (i_mem_ready) begin
                    state_d = S_MEMWB;
                end else if (expire) begin
                    cause_d = 1'b1;
                    state_d = S_TRAP;
                end
            end
            S_MEMWB: begin
                result_src = RES_READDATA;
                reg_write  = 1'b1;
                retire     = 1'b1;
                state_d    = S_FETCH;
            end
            S_MEMWRITE: begin
                mem_req = 1'b1;
                adr_src = 1'b1;
                if (i_mem_ready) begin
                    mem_write = 1'b1;
                    retire    = 1'b1;
                    state_d   = S_FETCH;
                end else if (expire) begin
                    cause_d = 1'b1;
                    state_d = S_TRAP;
                end
            end
            S_EXECR: begin
                alu_src_a = SRCA_RD1;
                alu_src_b = SRCB_RD2;
                alu_op    = ALUOP_FUNCT;
                state_d   = S_ALUWB;
            end
            S_EXECI: begin
                alu_src_a = SRCA_RD1;
                alu_src_b = SRCB_IMM;
                alu_op    = ALUOP_FUNCT;
                imm_src   = IMM_I;
                state_d   = S_ALUWB;
            end
            S_ALUWB: begin
                result_src = RES_ALUOUT;
                reg_write  = 1'b1;
                retire     = 1'b1;
                state_d    = S_FETCH;
            end
            S_BEQ: begin
                alu_src_a  = SRCA_RD1;
                alu_src_b  = SRCB_RD2;
                alu_op     = ALUOP_SUB;
                imm_src    = IMM_SB;
                result_src = RES_ALUOUT;
                branch     = 1'b1;
                pc_write   = i_zero;
                retire     = 1'b1;
                state_d    = S_FETCH;
            end
            S_TRAP: begin
                fault   = 1'b1;
                state_d = S_FETCH;
            end
            default: state_d = S_FETCH;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q   <= S_FETCH;
            cause_q   <= 1'b0;
            instret_q <= '0;
        end else begin
            state_q <= state_d;
            cause_q <= cause_d;
            if (retire) begin
                instret_q <= instret_q + CNT_WIDTH'(1);
            end
        end
    end

    // Every output is forced low while reset is asserted, aborting any access in flight.
    assign o_mem_req     = i_rst_n & mem_req;
    assign o_AdrSrc      = i_rst_n & adr_src;
    assign o_IRWrite     = i_rst_n & ir_write;
    assign o_PCWrite     = i_rst_n & pc_write;
    assign o_MemWrite    = i_rst_n & mem_write;
    assign o_RegWrite    = i_rst_n & reg_write;
    assign o_Branch      = i_rst_n & branch;
    assign o_ImmSrc      = i_rst_n ? imm_src    : 2'b00;
    assign o_ALUSrcA     = i_rst_n ? alu_src_a  : 2'b00;
    assign o_ALUSrcB     = i_rst_n ? alu_src_b  : 2'b00;
    assign o_ALUOp       = i_rst_n ? alu_op     : 2'b00;
    assign o_ResultSrc   = i_rst_n ? result_src : 2'b00;
    assign o_fault       = i_rst_n & fault;
    assign o_fault_cause = i_rst_n & fault & cause_q;
    assign o_instret     = i_rst_n ? instret_q : '0;

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// tb/tb_multicycle_ctrl_fsm.sv - randomized self-checking bench for multicycle_ctrl_fsm against an instruction-level model
module tb_multicycle_ctrl_fsm;

    localparam int TO = 5;
    localparam int CW = 4;
    localparam logic [6:0] LD = 7'b0000011, ST = 7'b0100011, RT = 7'b0110011,
                           IT = 7'b0010011, BR = 7'b1100011;

    logic          clk, rst_n, zero, mem_ready;
    logic [6:0]    opcode;
    logic          mem_req, adr, irw, pcw, mw, rw, br, fault, cause;
    logic [1:0]    imm, sa, sb, aop, rs;
    logic [CW-1:0] instret;

    multicycle_ctrl_fsm #(.OPCODE_WIDTH(7), .MEM_TIMEOUT(TO), .CNT_WIDTH(CW)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_opcode(opcode), .i_zero(zero), .i_mem_ready(mem_ready),
        .o_mem_req(mem_req), .o_AdrSrc(adr), .o_IRWrite(irw), .o_PCWrite(pcw), .o_MemWrite(mw),
        .o_RegWrite(rw), .o_Branch(br), .o_ImmSrc(imm), .o_ALUSrcA(sa), .o_ALUSrcB(sb),
        .o_ALUOp(aop), .o_ResultSrc(rs), .o_fault(fault), .o_fault_cause(cause), .o_instret(instret)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [6:0]    op;
        logic          rdy;
        logic          z;
        logic [18:0]   exp;
        logic [CW-1:0] cnt;
    } cyc_t;

    cyc_t          q[$];
    cyc_t          cy;
    int            m_cnt;
    int            vectors;
    int            miscompares;
    logic [18:0]   ob;
    logic [CW-1:0] oc;
    logic [18:0]   v_fidle, v_fdone, v_dec, v_madr_l, v_madr_s, v_mrd, v_mwr_done,
                   v_mwb, v_exr, v_exi, v_awb, v_trap0, v_trap1;

    // strobes = {mem_req, AdrSrc, IRWrite, PCWrite, MemWrite, RegWrite, Branch}; fc = {fault, cause}
    function automatic logic [18:0] mk(input logic [6:0] s, input logic [1:0] im, input logic [1:0] a,
                                       input logic [1:0] b, input logic [1:0] op, input logic [1:0] r,
                                       input logic [1:0] fc);
        return {s, im, a, b, op, r, fc};
    endfunction

    function automatic logic rz();
        return 1'($urandom_range(0, 1));
    endfunction

    task automatic init_vecs();
        v_fidle    = mk(7'b1000000, 2'b00, 2'b00, 2'b10, 2'b00, 2'b10, 2'b00);
        v_fdone    = mk(7'b1011000, 2'b00, 2'b00, 2'b10, 2'b00, 2'b10, 2'b00);
        v_dec      = mk(7'b0000000, 2'b10, 2'b01, 2'b01, 2'b00, 2'b00, 2'b00);
        v_madr_l   = mk(7'b0000000, 2'b00, 2'b10, 2'b01, 2'b00, 2'b00, 2'b00);
        v_madr_s   = mk(7'b0000000, 2'b01, 2'b10, 2'b01, 2'b00, 2'b00, 2'b00);
        v_mrd      = mk(7'b1100000, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
        v_mwr_done = mk(7'b1100100, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
        v_mwb      = mk(7'b0000010, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01, 2'b00);
        v_exr      = mk(7'b0000000, 2'b00, 2'b10, 2'b00, 2'b10, 2'b00, 2'b00);
        v_exi      = mk(7'b0000000, 2'b00, 2'b10, 2'b01, 2'b10, 2'b00, 2'b00);
        v_awb      = mk(7'b0000010, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
        v_trap0    = mk(7'b0000000, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b10);
        v_trap1    = mk(7'b0000000, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b11);
    endtask

    task automatic push(input logic [6:0] op, input logic rdy, input logic z, input logic [18:0] e);
        cyc_t c;
        c.op = op; c.rdy = rdy; c.z = z; c.exp = e; c.cnt = CW'(m_cnt);
        q.push_back(c);
    endtask

    task automatic retire_one();
        m_cnt = (m_cnt + 1) % (1 << CW);
    endtask

    // A memory access: `waits` idle cycles then ready; TO or more waits means a timeout trap.
    task automatic access(input logic [6:0] op, input logic [18:0] idle, input logic [18:0] done,
                          input int waits, output logic ok);
        ok = (waits < TO);
        for (int i = 0; i < (ok ? waits : TO); i++) push(op, 1'b0, rz(), idle);
        if (ok) push(op, 1'b1, rz(), done);
        else    push(op, 1'b0, rz(), v_trap1);
    endtask

    task automatic add_instr(input logic [6:0] op, input int wf, input int wm, input int zsel);
        logic ok;
        logic z;
        access(op, v_fidle, v_fdone, wf, ok);
        if (!ok) return;
        push(op, 1'b0, rz(), v_dec);
        case (op)
            LD: begin
                push(op, 1'b0, rz(), v_madr_l);
                access(op, v_mrd, v_mrd, wm, ok);
                if (ok) begin
                    push(op, 1'b0, rz(), v_mwb);
                    retire_one();
                end
            end
            ST: begin
                push(op, 1'b0, rz(), v_madr_s);
                access(op, v_mrd, v_mwr_done, wm, ok);
                if (ok) retire_one();
            end
            RT: begin
                push(op, 1'b0, rz(), v_exr);
                push(op, 1'b0, rz(), v_awb);
                retire_one();
            end
            IT: begin
                push(op, 1'b0, rz(), v_exi);
                push(op, 1'b0, rz(), v_awb);
                retire_one();
            end
            BR: begin
                z = (zsel < 0) ? rz() : 1'(zsel);
                push(op, 1'b0, z, mk({3'b000, z, 3'b001}, 2'b10, 2'b10, 2'b00, 2'b01, 2'b00, 2'b00));
                retire_one();
            end
            default: push(op, 1'b0, rz(), v_trap0);
        endcase
    endtask

    task automatic apply(input logic [6:0] op, input logic rdy, input logic z,
                         output logic [18:0] o, output logic [CW-1:0] c);
        opcode = op; mem_ready = rdy; zero = z;
        #3;
        o = {mem_req, adr, irw, pcw, mw, rw, br, imm, sa, sb, aop, rs, fault, cause};
        c = instret;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            apply(7'($urandom), rz(), rz(), ob, oc);
            vectors++;
            if (ob !== 19'd0 || oc !== '0) begin
                miscompares++;
                $display("FAIL reset_outputs: got %h/%0d want 0/0", ob, oc);
            end
        end
        rst_n = 1'b1;
        m_cnt = 0;
        add_instr(RT, 2, 0, -1);
        while (q.size() > 0) begin
            cy = q.pop_front();
            apply(cy.op, cy.rdy, cy.z, ob, oc);
            vectors++;
            if (ob !== cy.exp || oc !== cy.cnt) begin
                miscompares++;
                $display("FAIL reset_then_rtype: got %h/%0d want %h/%0d", ob, oc, cy.exp, cy.cnt);
            end
        end
    endtask

    task automatic test_alu_mem();
        add_instr(IT, 0, 0, -1);
        add_instr(LD, 0, 0, -1);
        add_instr(ST, 0, 0, -1);
        add_instr(ST, 1, 3, -1);
        add_instr(LD, 3, 2, -1);
        add_instr(BR, 0, 0, 1);
        add_instr(BR, 1, 0, 0);
        while (q.size() > 0) begin
            cy = q.pop_front();
            apply(cy.op, cy.rdy, cy.z, ob, oc);
            vectors++;
            if (ob !== cy.exp || oc !== cy.cnt) begin
                miscompares++;
                $display("FAIL alu_mem_branch op=%b: got %h/%0d want %h/%0d", cy.op, ob, oc, cy.exp, cy.cnt);
            end
        end
    endtask

    task automatic test_illegal_and_timeout();
        add_instr(7'b1111111, 0, 0, -1);
        add_instr(RT, 0, 0, -1);
        add_instr(LD, 0, TO, -1);
        add_instr(LD, 0, TO - 1, -1);
        add_instr(ST, 0, TO + 3, -1);
        add_instr(ST, 1, TO - 1, -1);
        add_instr(RT, TO, 0, -1);
        add_instr(RT, TO - 1, 0, -1);
        while (q.size() > 0) begin
            cy = q.pop_front();
            apply(cy.op, cy.rdy, cy.z, ob, oc);
            vectors++;
            if (ob !== cy.exp || oc !== cy.cnt) begin
                miscompares++;
                $display("FAIL trap_timeout op=%b: got %h/%0d want %h/%0d", cy.op, ob, oc, cy.exp, cy.cnt);
            end
        end
    endtask

    task automatic test_reset_mid_op();
        logic ok;
        access(LD, v_fidle, v_fdone, 0, ok);
        push(LD, 1'b0, rz(), v_dec);
        push(LD, 1'b0, rz(), v_madr_l);
        push(LD, 1'b0, rz(), v_mrd);
        push(LD, 1'b0, rz(), v_mrd);
        while (q.size() > 0) begin
            cy = q.pop_front();
            apply(cy.op, cy.rdy, cy.z, ob, oc);
            vectors++;
            if (ob !== cy.exp || oc !== cy.cnt) begin
                miscompares++;
                $display("FAIL pre_reset_memread: got %h/%0d want %h/%0d", ob, oc, cy.exp, cy.cnt);
            end
        end
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            apply(LD, 1'b1, rz(), ob, oc);
            vectors++;
            if (ob !== 19'd0 || oc !== '0) begin
                miscompares++;
                $display("FAIL mid_reset_outputs: got %h/%0d want 0/0", ob, oc);
            end
        end
        rst_n = 1'b1;
        m_cnt = 0;
        add_instr(RT, 0, 0, -1);
        while (q.size() > 0) begin
            cy = q.pop_front();
            apply(cy.op, cy.rdy, cy.z, ob, oc);
            vectors++;
            if (ob !== cy.exp || oc !== cy.cnt) begin
                miscompares++;
                $display("FAIL post_reset_fetch: got %h/%0d want %h/%0d", ob, oc, cy.exp, cy.cnt);
            end
        end
    endtask

    task automatic test_instret_wrap();
        for (int i = 0; i < (1 << CW) + 2; i++) add_instr(RT, int'($urandom_range(0, 1)), 0, -1);
        while (q.size() > 0) begin
            cy = q.pop_front();
            apply(cy.op, cy.rdy, cy.z, ob, oc);
            vectors++;
            if (ob !== cy.exp || oc !== cy.cnt) begin
                miscompares++;
                $display("FAIL instret_wrap: got %h/%0d want %h/%0d", ob, oc, cy.exp, cy.cnt);
            end
        end
    endtask

    task automatic test_random();
        logic [6:0] op;
        logic [6:0] legal [5];
        legal = '{LD, ST, RT, IT, BR};
        for (int n = 0; n < 60; n++) begin
            if ($urandom_range(0, 7) == 0) begin
                do op = 7'($urandom); while (op == LD || op == ST || op == RT || op == IT || op == BR);
            end else begin
                op = legal[$urandom_range(0, 4)];
            end
            add_instr(op,
                      ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, TO + 1)) : int'($urandom_range(0, 1)),
                      ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, TO + 1)) : int'($urandom_range(0, 1)),
                      -1);
        end
        while (q.size() > 0) begin
            cy = q.pop_front();
            apply(cy.op, cy.rdy, cy.z, ob, oc);
            vectors++;
            if (ob !== cy.exp || oc !== cy.cnt) begin
                miscompares++;
                $display("FAIL random op=%b rdy=%b z=%b: got %h/%0d want %h/%0d",
                         cy.op, cy.rdy, cy.z, ob, oc, cy.exp, cy.cnt);
            end
        end
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        m_cnt = 0;
        rst_n = 1'b0;
        opcode = 7'd0;
        zero = 1'b0;
        mem_ready = 1'b0;
        init_vecs();
        @(posedge clk);
        #1;
        test_reset();
        test_alu_mem();
        test_illegal_and_timeout();
        test_reset_mid_op();
        test_instret_wrap();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
